// File: rtl/le_bist_checker_pkg.sv
// Shared definitions for the LE logic unit and its BIST checker:
// select codes and checker FSM states.
package le_bist_checker_pkg;

   localparam logic [1:0] LE_AND  = 2'b00;
   localparam logic [1:0] LE_OR   = 2'b01;
   localparam logic [1:0] LE_XOR  = 2'b10;
   localparam logic [1:0] LE_NOTA = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIN  = 2'b10
   } state_t;

endpackage

// File: rtl/le_bist_checker_ref_model.sv
// Combinational golden model of the LE logic unit (a, b, sel -> expected e).
module le_ref_model
   import le_bist_checker_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] e_exp
);

   always_comb begin
      e_exp = '0;
      unique case (sel)
         LE_AND:  e_exp = a & b;
         LE_OR:   e_exp = a | b;
         LE_XOR:  e_exp = a ^ b;
         LE_NOTA: e_exp = ~a;
         default: e_exp = '0;
      endcase
   end

endmodule

// File: rtl/le_bist_checker.sv
// BIST engine for the LE logic unit: sweeps every {sel,a,b} vector, checks LE's
// result against the golden model and reports pass, error count and first failure.
module le_bist_checker
   import le_bist_checker_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int VEC_W = 2*WIDTH + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] le_a,
   output logic [WIDTH-1:0] le_b,
   output logic [1:0]       le_sel,
   input  logic [WIDTH-1:0] le_e,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [VEC_W:0]   err_count,
   output logic [VEC_W-1:0] fail_vec
);

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [VEC_W:0]     err_count_q, err_count_d;
   logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
   logic               pass_q, pass_d;
   logic [WIDTH-1:0]   e_exp;
   logic               mismatch;
   logic               last_vec;

   // The vector register drives LE directly, so the check is on the current vector.
   assign le_sel = vec_q[VEC_W-1 -: 2];
   assign le_a   = vec_q[2*WIDTH-1 -: WIDTH];
   assign le_b   = vec_q[WIDTH-1:0];

   le_ref_model #(.WIDTH(WIDTH)) u_ref (
      .a     (le_a),
      .b     (le_b),
      .sel   (le_sel),
      .e_exp (e_exp)
   );

   // Case-inequality so an unknown LE result counts as a failure in simulation.
   assign mismatch = (le_e !== e_exp);
   assign last_vec = &vec_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start)    state_d = ST_RUN;
         ST_RUN:  if (last_vec) state_d = ST_FIN;
         ST_FIN:                state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_FIN);
   end

   always_comb begin
      vec_d       = vec_q;
      err_count_d = err_count_q;
      fail_vec_d  = fail_vec_q;
      pass_d      = pass_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               vec_d       = '0;
               err_count_d = '0;
               fail_vec_d  = '0;
               pass_d      = 1'b0;
            end
         end
         ST_RUN: begin
            if (mismatch) begin
               err_count_d = err_count_q + (VEC_W+1)'(1);
               if (err_count_q == '0) fail_vec_d = vec_q;
            end
            if (!last_vec) vec_d = vec_q + VEC_W'(1);
         end
         ST_FIN:  pass_d = (err_count_q == '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q       <= '0;
         err_count_q <= '0;
         fail_vec_q  <= '0;
         pass_q      <= 1'b0;
      end else begin
         vec_q       <= vec_d;
         err_count_q <= err_count_d;
         fail_vec_q  <= fail_vec_d;
         pass_q      <= pass_d;
      end
   end

   assign err_count = err_count_q;
   assign fail_vec  = fail_vec_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_le_bist_checker.sv
// Self-checking bench for le_bist_checker: emulates LE (good and faulty variants)
// and predicts sweep results from a whole-sweep reference model.
module tb_le_bist_checker;

   localparam int WIDTH = 4;
   localparam int VEC_W = 2*WIDTH + 2;
   localparam int NVEC  = 1 << VEC_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] le_a, le_b, le_e;
   logic [1:0]       le_sel;
   logic             busy, done, pass;
   logic [VEC_W:0]   err_count;
   logic [VEC_W-1:0] fail_vec;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // LE emulation: 0 good, 1 E[0] stuck-at-0, 2 sel=10 gives A|B, 3 all inverted,
   // 4 random flips per vector, 5 unknown result on xvec, 6 last vector corrupted
   int               mode = 0;
   logic             flip_bit [NVEC];
   logic [3:0]       flip_val [NVEC];
   logic [VEC_W-1:0] xvec = '0;
   logic [3:0]       xval;

   le_bist_checker #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .le_a      (le_a),
      .le_b      (le_b),
      .le_sel    (le_sel),
      .le_e      (le_e),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] golden(input logic [9:0] v);
      logic [1:0] s;
      logic [3:0] a, b;
      s = v[9:8]; a = v[7:4]; b = v[3:0];
      case (s)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   function automatic logic [3:0] le_emul(input int m, input logic [9:0] v, input logic fb,
                                          input logic [3:0] fv, input logic [9:0] xv,
                                          input logic [3:0] xval_i);
      logic [3:0] g;
      g = golden(v);
      case (m)
         1: return g & 4'b1110;
         2: return (v[9:8] == 2'b10) ? (v[7:4] | v[3:0]) : g;
         3: return ~g;
         4: return fb ? (g ^ fv) : g;
         5: return (v == xv) ? xval_i : g;
         6: return (v == 10'h3FF) ? (g ^ 4'h1) : g;
         default: return g;
      endcase
   endfunction

   always_comb begin
      le_e = le_emul(mode, {le_sel, le_a, le_b}, flip_bit[{le_sel, le_a, le_b}],
                     flip_val[{le_sel, le_a, le_b}], xvec, xval);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Whole-sweep prediction: count every vector where LE disagrees with the truth table.
   task automatic model_sweep(output int errs, output int first);
      logic [3:0] e;
      logic [9:0] v;
      errs = 0; first = 0;
      for (int i = 0; i < NVEC; i++) begin
         v = 10'(i);
         e = le_emul(mode, v, flip_bit[i], flip_val[i], xvec, xval);
         if (e !== golden(v)) begin
            if (errs == 0) first = i;
            errs++;
         end
      end
   endtask

   task automatic run_sweep(input string tag, input bit exp_pass, input int exp_err,
                            input int exp_fv, input bit pokes);
      int busy_n = 0;
      int guard  = 0;
      int extra  = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (!done && guard < 1100) begin
         if (busy) busy_n++;
         start = (pokes && busy_n == 300);
         guard++;
         @(negedge clk);
      end
      check({tag, " done_seen"}, 32'(done), 32'd1);
      check({tag, " run_len"}, busy_n, NVEC);
      check({tag, " err_count"}, 32'(err_count), exp_err);
      check({tag, " fail_vec"}, 32'(fail_vec), exp_fv);
      check({tag, " le_final"}, {22'd0, le_sel, le_a, le_b}, 32'h3FF);
      start = pokes;
      @(negedge clk) start = 1'b0;
      check({tag, " done_width"}, 32'(done), 32'd0);
      check({tag, " busy_after"}, 32'(busy), 32'd0);
      check({tag, " pass"}, 32'(pass), 32'(exp_pass));
      if (pokes) begin
         repeat (20) begin
            @(negedge clk);
            if (done || busy) extra++;
         end
         check({tag, " no_restart"}, extra, 0);
      end
   endtask

   task automatic run_model_sweep(input string tag);
      int errs, first;
      model_sweep(errs, first);
      run_sweep(tag, errs == 0, errs, first, 1'b0);
   endtask

   typedef struct {
      int    m;
      bit    exp_pass;
      int    exp_err;
      int    exp_fv;
      string name;
   } vec_t;

   initial begin
      vec_t tbl [5];
      int   busy_n, guard, ndone, dones_seen;
      int   done_cyc [3];

      xval = 4'bxxxx;
      for (int i = 0; i < NVEC; i++) begin
         flip_bit[i] = 1'b0;
         flip_val[i] = 4'h0;
      end

      // E[0] stuck-at-0 misses a0&b0, a0|b0, a0^b0 and ~a0 ones: 64+192+128+128.
      // sel=10 as A|B fails wherever A&B!=0: 256 - 3^4 = 175 vectors.
      tbl[0] = '{0, 1'b1, 0,    10'h000, "good"};
      tbl[1] = '{1, 1'b0, 512,  10'h011, "e0_stuck0"};
      tbl[2] = '{2, 1'b0, 175,  10'h211, "xor_as_or"};
      tbl[3] = '{3, 1'b0, 1024, 10'h000, "all_wrong"};
      tbl[4] = '{6, 1'b0, 1,    10'h3FF, "last_vec"};

      repeat (3) @(negedge clk);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst pass", 32'(pass), 0);
      check("rst err_count", 32'(err_count), 0);
      check("rst fail_vec", 32'(fail_vec), 0);
      check("rst le", {22'd0, le_sel, le_a, le_b}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle no start", 32'(busy), 0);

      foreach (tbl[i]) begin
         mode = tbl[i].m;
         run_sweep(tbl[i].name, tbl[i].exp_pass, tbl[i].exp_err, tbl[i].exp_fv, 1'b0);
      end

      mode = 4;
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < NVEC; i++) begin
            flip_bit[i] = (it != 0) && ($urandom_range(0, 63) == 0);
            flip_val[i] = 4'($urandom_range(1, 15));
         end
         run_model_sweep($sformatf("rand%0d", it));
      end

      mode = 5;
      xvec = 10'b11_0000_0101;
      run_model_sweep("x_inject");

      // Reset in the middle of a failing sweep
      mode = 1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      busy_n = 0;
      guard  = 0;
      while (busy_n < 500 && guard < 1100) begin
         if (busy) busy_n++;
         guard++;
         @(negedge clk);
      end
      check("pre_rst err_nonzero", 32'(err_count != 0), 1);
      #2 rst = 1'b1;
      #1;
      check("async rst busy", 32'(busy), 0);
      check("async rst err_count", 32'(err_count), 0);
      check("async rst fail_vec", 32'(fail_vec), 0);
      check("async rst le", {22'd0, le_sel, le_a, le_b}, 0);
      @(negedge clk) rst = 1'b0;
      dones_seen = 0;
      repeat (1100) begin
         @(negedge clk);
         if (done || busy) dones_seen++;
      end
      check("aborted no done", dones_seen, 0);
      run_sweep("after_rst", 1'b0, 512, 10'h011, 1'b0);

      mode = 0;
      run_sweep("start_pokes", 1'b1, 0, 0, 1'b1);

      // start held high: sweeps chain with one idle cycle between them
      @(negedge clk) start = 1'b1;
      ndone = 0;
      guard = 0;
      while (ndone < 3 && guard < 4000) begin
         @(negedge clk);
         guard++;
         if (done) begin
            done_cyc[ndone] = cyc;
            ndone++;
         end
      end
      start = 1'b0;
      check("held done count", ndone, 3);
      if (ndone == 3) begin
         check("held period 1", done_cyc[1] - done_cyc[0], 1026);
         check("held period 2", done_cyc[2] - done_cyc[1], 1026);
      end
      repeat (3) @(negedge clk);
      check("held stop idle", 32'(busy), 0);
      check("held pass", 32'(pass), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
